// File: rtl/ring_osc_meter.sv
// Ring-oscillator controller: gates the ring, selects a tap and counts synchronised
// rising edges of that tap over a programmed window of clk cycles.
module ring_osc_meter #(
    parameter int unsigned N_STAGES    = 50,
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned TAP_W      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [TAP_W-1:0] tap_sel,
    input  logic [WIN_W-1:0] win_cycles,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             ring_en,
    output logic [TAP_W-1:0] ring_tap_sel,
    input  logic             ring_tap
);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, STOP} state_t;

    state_t                 state_q, state_nxt;
    logic [WIN_W-1:0]       timer_q, timer_nxt;
    logic [WIN_W-1:0]       win_q;
    logic                   aborted_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_tap;
    logic                   tap_ok_c;
    logic                   accept_c;
    logic                   reject_c;
    logic                   abort_c;
    logic                   edge_c;

    assign sync_tap = sync_q[SYNC_STAGES-1];
    assign tap_ok_c = {1'b0, tap_sel} < (TAP_W+1)'(N_STAGES);
    assign edge_c   = (state_q == MEASURE) && sync_tap && !prev_q;

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        accept_c  = 1'b0;
        reject_c  = 1'b0;
        abort_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (tap_ok_c) begin
                        accept_c  = 1'b1;
                        state_nxt = SETTLE;
                        timer_nxt = WIN_W'(SETTLE_CYC - 1);
                    end else begin
                        reject_c = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    abort_c   = 1'b1;
                    state_nxt = STOP;
                end else if (timer_q == '0) begin
                    state_nxt = (win_q == '0) ? STOP : MEASURE;
                    timer_nxt = win_q - WIN_W'(1);
                end else begin
                    timer_nxt = timer_q - WIN_W'(1);
                end
            end
            MEASURE: begin
                if (abort) begin
                    abort_c   = 1'b1;
                    state_nxt = STOP;
                end else if (timer_q == '0) begin
                    state_nxt = STOP;
                end else begin
                    timer_nxt = timer_q - WIN_W'(1);
                end
            end
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            win_q        <= '0;
            aborted_q    <= 1'b0;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            count        <= '0;
            overflow     <= 1'b0;
            ring_en      <= 1'b0;
            ring_tap_sel <= '0;
        end else begin
            state_q <= state_nxt;
            timer_q <= timer_nxt;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ring_tap};
            // History tracks the synchronised tap every cycle, so it is primed in SETTLE
            prev_q  <= sync_tap;
            done    <= (state_q == STOP) && !aborted_q;
            err     <= reject_c;

            if (accept_c) begin
                win_q        <= win_cycles;
                ring_tap_sel <= tap_sel;
                count        <= '0;
                overflow     <= 1'b0;
                aborted_q    <= 1'b0;
                busy         <= 1'b1;
                ring_en      <= 1'b1;
            end else if (edge_c) begin
                if (count == {CNT_W{1'b1}}) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end

            if (abort_c) begin
                aborted_q <= 1'b1;
            end

            // Ring stays enabled through STOP and drops together with busy
            if (state_q == STOP) begin
                busy    <= 1'b0;
                ring_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench for ring_osc_meter: a square-wave tap model drives a default instance
// and a narrow-counter instance that shares every input.
module tb_ring_osc_meter;

    localparam int unsigned TAP_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [TAP_W-1:0] tap_sel = '0;
    logic [15:0]      win_cycles = '0;
    logic             ring_tap = 1'b0;

    logic             busy_a, done_a, err_a, ovf_a, ring_en_a;
    logic [19:0]      count_a;
    logic [TAP_W-1:0] rsel_a;
    logic             busy_b, done_b, err_b, ovf_b, ring_en_b;
    logic [3:0]       count_b;
    logic [TAP_W-1:0] rsel_b;

    int checks = 0;
    int errors = 0;
    int half   = 5;
    int ph     = 0;

    ring_osc_meter dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tap_sel(tap_sel),
        .win_cycles(win_cycles), .busy(busy_a), .done(done_a), .err(err_a),
        .count(count_a), .overflow(ovf_a), .ring_en(ring_en_a),
        .ring_tap_sel(rsel_a), .ring_tap(ring_tap)
    );

    ring_osc_meter #(.CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tap_sel(tap_sel),
        .win_cycles(win_cycles), .busy(busy_b), .done(done_b), .err(err_b),
        .count(count_b), .overflow(ovf_b), .ring_en(ring_en_b),
        .ring_tap_sel(rsel_b), .ring_tap(ring_tap)
    );

    always #5 clk = ~clk;

    // Square-wave ring model: period 2*half clk cycles
    always @(negedge clk) begin
        ph = ph + 1;
        if (ph >= half) begin
            ph = 0;
            ring_tap = ~ring_tap;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits for done on the default instance; returns cycles since the start cycle
    // and the number of cycles ring_en was high.
    task automatic wait_done(output int n, output int en, output int got);
        n = 1; en = 0; got = 0;
        while (n < 400) begin
            if (ring_en_a) en++;
            if (done_a) begin
                got = 1;
                break;
            end
            cyc();
            n++;
        end
    endtask

    typedef struct {
        int tap;
        int win;
        int hp;
        int exp_cnt;
        int exp_err;
    } vec_t;

    vec_t vecs[6];
    int n, en, got;

    initial begin
        vecs[0] = '{tap: 7,  win: 100, hp: 5, exp_cnt: 10, exp_err: 0};
        vecs[1] = '{tap: 0,  win: 0,   hp: 5, exp_cnt: 0,  exp_err: 0};
        vecs[2] = '{tap: 50, win: 10,  hp: 5, exp_cnt: 0,  exp_err: 1};
        vecs[3] = '{tap: 49, win: 30,  hp: 3, exp_cnt: 5,  exp_err: 0};
        vecs[4] = '{tap: 12, win: 40,  hp: 2, exp_cnt: 10, exp_err: 0};
        vecs[5] = '{tap: 63, win: 5,   hp: 2, exp_cnt: 0,  exp_err: 1};

        // Reset values
        #2;
        check("rst_busy", busy_a, 0);
        check("rst_ring_en", ring_en_a, 0);
        check("rst_count", count_a, 0);
        check("rst_tap_sel", rsel_a, 0);
        check("rst_done_err", {done_a, err_a, ovf_a}, 0);
        cyc();
        rst = 1'b0;
        cyc();

        foreach (vecs[i]) begin
            half = vecs[i].hp;
            repeat (3) cyc();
            tap_sel    = TAP_W'(vecs[i].tap);
            win_cycles = 16'(vecs[i].win);
            start      = 1'b1;
            cyc();
            start = 1'b0;
            if (vecs[i].exp_err != 0) begin
                check($sformatf("v%0d_err", i), err_a, 1);
                check($sformatf("v%0d_err_busy", i), busy_a, 0);
                check($sformatf("v%0d_err_en", i), ring_en_a, 0);
                cyc();
                check($sformatf("v%0d_err_pulse", i), err_a, 0);
            end else begin
                check($sformatf("v%0d_busy", i), busy_a, 1);
                check($sformatf("v%0d_tap_sel", i), rsel_a, vecs[i].tap);
                wait_done(n, en, got);
                check($sformatf("v%0d_done_seen", i), got, 1);
                check($sformatf("v%0d_latency", i), n, vecs[i].win + 6);
                check($sformatf("v%0d_en_cycles", i), en, vecs[i].win + 5);
                check($sformatf("v%0d_count", i), count_a, vecs[i].exp_cnt);
                check($sformatf("v%0d_ovf", i), ovf_a, 0);
                check($sformatf("v%0d_busy_off", i), busy_a, 0);
                cyc();
                check($sformatf("v%0d_done_pulse", i), done_a, 0);
                check($sformatf("v%0d_count_hold", i), count_a, vecs[i].exp_cnt);
            end
        end

        // Saturation on the 4-bit counter instance
        half = 2;
        repeat (3) cyc();
        tap_sel = 6'd5; win_cycles = 16'd200; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(n, en, got);
        check("sat_latency", n, 206);
        check("sat_done_b", done_b, 1);
        check("sat_count_b", count_b, 15);
        check("sat_ovf_b", ovf_b, 1);
        check("sat_count_a", count_a, 50);
        check("sat_ovf_a", ovf_a, 0);
        cyc();

        // Start and abort together in IDLE: start wins
        tap_sel = 6'd2; win_cycles = 16'd0; start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", busy_a, 1);
        wait_done(n, en, got);
        check("sa_latency", n, 6);
        cyc();

        // Abort 20 cycles into MEASURE; a start while busy is ignored
        half = 5;
        repeat (3) cyc();
        tap_sel = 6'd3; win_cycles = 16'd100; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (24) cyc();
        abort = 1'b1; start = 1'b1; tap_sel = 6'd9; win_cycles = 16'd7;
        cyc();
        abort = 1'b0; start = 1'b0;
        check("ab_stop_busy", busy_a, 1);
        cyc();
        check("ab_busy", busy_a, 0);
        check("ab_ring_en", ring_en_a, 0);
        check("ab_tap_kept", rsel_a, 3);
        check("ab_partial", int'(count_a >= 20'd2 && count_a <= 20'd3), 1);
        got = 0;
        repeat (10) begin
            if (done_a) got = 1;
            cyc();
        end
        check("ab_no_done", got, 0);

        // Asynchronous reset mid-MEASURE
        tap_sel = 6'd7; win_cycles = 16'd100; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (20) cyc();
        check("rm_busy_before", busy_a, 1);
        #2 rst = 1'b1;
        #1;
        check("rm_busy", busy_a, 0);
        check("rm_ring_en", ring_en_a, 0);
        check("rm_count", count_a, 0);
        check("rm_tap_sel", rsel_a, 0);
        cyc();
        rst = 1'b0;
        repeat (3) cyc();
        check("rm_idle", {busy_a, ring_en_a, done_a}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
